turn_sequencer: RTL and testbench
=================================

Name: turn_sequencer

Overview:
- Sequences one game between the human player and the PC: grants turns, runs the 15-second player turn timer, commits accepted moves to the board, and waits on the external win/draw checker before handing the turn over.
- Sits between the input debouncers, the PC move generator, the board register file and the win checker.
- Its one-hot state outputs drive the display and turn LEDs.

Parameters:
- TICKS_PER_SEC, 50_000_000, clk cycles per one-second timer tick (tests use 4).
- TURN_SEC, 15, seconds allowed per player turn (1..15).
- MOVE_W, 4, width of a board cell index.

Ports:
- clk  input  1  system clock; single clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a game (from IDLE or GAME_OVER)
- p_valid  input  1  player move strobe
- p_move  input  MOVE_W  player cell index
- pc_valid  input  1  PC move strobe
- pc_move  input  MOVE_W  PC cell index
- chk_done  input  1  win checker result valid (single-cycle)
- chk_win  input  1  last committed move wins; sampled with chk_done
- chk_draw  input  1  board full, no winner; sampled with chk_done
- player_turn  output  1  high in PLAYER; doubles as p_ready
- pc_turn  output  1  high in PC; doubles as pc_ready
- timer_run  output  1  high in PLAYER
- sec_left  output  4  remaining seconds of the player turn
- wr_en  output  1  one-cycle board write strobe
- wr_addr  output  MOVE_W  cell to write
- wr_who  output  1  0 = player, 1 = PC
- chk_start  output  1  one-cycle checker start pulse
- game_over  output  1  high in OVER
- winner  output  2  00 none, 01 player, 10 PC, 11 draw
- timeout  output  1  one-cycle pulse when a player turn expires

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0; sec_left = 0; winner = 00; the tick counter and the latched move are cleared.
  - Reset mid-game aborts with no write.
- States: IDLE, PLAYER, PC, COMMIT, CHECK, OVER (registered state; outputs decoded from registered state or registers only).
- IDLE:
  - start=1 -> PLAYER on the next cycle.
  - The same edge loads sec_left = TURN_SEC, tick counter = 0, winner = 00.
- PLAYER:
  - Tick counter counts 0..TICKS_PER_SEC-1 and wraps.
  - On wrap, sec_left decrements.
  - Timeout: the wrap while sec_left == 1 sets sec_left = 0, pulses timeout for 1 cycle, and moves to PC with no write.
  - p_valid=1: latch p_move and wr_who = 0, go to COMMIT.
  - p_valid and the timeout wrap in the same cycle: the move wins and there is no timeout pulse.
  - p_valid outside PLAYER is ignored.
- PC:
  - No time limit.
  - pc_valid=1: latch pc_move and wr_who = 1, go to COMMIT.
  - pc_valid outside PC is ignored.
- COMMIT: wr_en = 1 with wr_addr / wr_who held; unconditional -> CHECK.
- CHECK:
  - chk_start is high on the first CHECK cycle only.
  - Waits indefinitely for chk_done.
  - chk_done & chk_win -> OVER, winner = {wr_who, ~wr_who}.
  - chk_done & chk_draw & ~chk_win -> OVER, winner = 11 (win has priority over draw).
  - chk_done with neither set -> other side's turn. Entering PLAYER reloads sec_left = TURN_SEC and tick counter = 0.
  - chk_done in the same cycle as chk_start is accepted.
- OVER:
  - game_over = 1; winner is held.
  - start=1 -> PLAYER with the same loads as from IDLE.
- Latency: a move accepted on cycle N gives wr_en on N+1, chk_start on N+2, and the earliest next-turn grant on N+3.
- Timer freeze: sec_left holds its value outside PLAYER, and the tick counter does not advance.
- wr_addr / wr_who hold their last value between commits.

Test Plan (TICKS_PER_SEC=4, TURN_SEC=3):
1. Reset, then start pulse -> player_turn=1 and sec_left=3 next cycle; sec_left 3→2→1 at 4-cycle intervals.
2. No p_valid for 12 cycles in PLAYER -> timeout pulse on cycle 12, sec_left=0, pc_turn=1 next cycle, wr_en never asserted.
3. p_valid with p_move=5 in PLAYER -> wr_en=1, wr_addr=5, wr_who=0 one cycle later; chk_start the cycle after; chk_done with no win/draw -> pc_turn=1, then pc_valid with pc_move=2 -> wr_addr=2, wr_who=1.
4. PC move, then chk_done=1, chk_win=1, chk_draw=1 -> game_over=1, winner=10; a p_valid pulse changes nothing; a start pulse -> player_turn=1, winner=00, sec_left=3.
5. p_valid asserted on the exact cycle sec_left goes 1→0 -> move committed (wr_en=1), no timeout pulse.
6. rst asserted in CHECK while waiting for chk_done -> next cycle all outputs 0 and state IDLE; a later chk_done is ignored.

Source files
------------

// File: rtl/turn_sequencer.sv
// turn_sequencer: runs one player-versus-PC game. It grants turns, times the
// player turn, commits accepted moves to the board and then waits on the
// external win/draw checker before handing the turn to the other side.
module turn_sequencer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TURN_SEC      = 15,
  parameter int MOVE_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              p_valid,
  input  logic [MOVE_W-1:0] p_move,
  input  logic              pc_valid,
  input  logic [MOVE_W-1:0] pc_move,
  input  logic              chk_done,
  input  logic              chk_win,
  input  logic              chk_draw,
  output logic              player_turn,
  output logic              pc_turn,
  output logic              timer_run,
  output logic [3:0]        sec_left,
  output logic              wr_en,
  output logic [MOVE_W-1:0] wr_addr,
  output logic              wr_who,
  output logic              chk_start,
  output logic              game_over,
  output logic [1:0]        winner,
  output logic              timeout
);

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [3:0]        SEC_RELOAD = 4'(TURN_SEC);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PLAYER = 3'd1;
  localparam logic [2:0] S_PC     = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_OVER   = 3'd5;

  logic [2:0]        state_q,     state_d;
  logic [TICK_W-1:0] tick_q,      tick_d;
  logic [3:0]        sec_q,       sec_d;
  logic [MOVE_W-1:0] addr_q,      addr_d;
  logic              who_q,       who_d;
  logic [1:0]        winner_q,    winner_d;
  logic              timeout_q,   timeout_d;
  logic              chk_start_q, chk_start_d;

  logic tick_wrap;

  assign tick_wrap = (tick_q == TICK_MAX);

  // Next-state, timer and move-latch logic for the game sequence
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    sec_d       = sec_q;
    addr_d      = addr_q;
    who_d       = who_q;
    winner_d    = winner_q;
    timeout_d   = 1'b0;
    chk_start_d = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d  = S_PLAYER;
          sec_d    = SEC_RELOAD;
          tick_d   = '0;
          winner_d = 2'b00;
        end
      end

      S_PLAYER: begin
        // The timer keeps running on the cycle a move is accepted, so a move
        // on the final wrap still leaves sec_left at 0.
        if (tick_wrap) begin
          tick_d = '0;
          if (sec_q != 4'd0) begin
            sec_d = sec_q - 4'd1;
          end
        end else begin
          tick_d = tick_q + TICK_ONE;
        end

        // A move beats a simultaneous expiry: no timeout pulse in that case.
        if (p_valid) begin
          addr_d  = p_move;
          who_d   = 1'b0;
          state_d = S_COMMIT;
        end else if (tick_wrap && (sec_q == 4'd1)) begin
          timeout_d = 1'b1;
          state_d   = S_PC;
        end
      end

      S_PC: begin
        if (pc_valid) begin
          addr_d  = pc_move;
          who_d   = 1'b1;
          state_d = S_COMMIT;
        end
      end

      S_COMMIT: begin
        chk_start_d = 1'b1;
        state_d     = S_CHECK;
      end

      S_CHECK: begin
        if (chk_done) begin
          if (chk_win) begin
            winner_d = {who_q, ~who_q};
            state_d  = S_OVER;
          end else if (chk_draw) begin
            winner_d = 2'b11;
            state_d  = S_OVER;
          end else if (who_q) begin
            state_d = S_PLAYER;
            sec_d   = SEC_RELOAD;
            tick_d  = '0;
          end else begin
            state_d = S_PC;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      sec_q       <= 4'd0;
      addr_q      <= '0;
      who_q       <= 1'b0;
      winner_q    <= 2'b00;
      timeout_q   <= 1'b0;
      chk_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      sec_q       <= sec_d;
      addr_q      <= addr_d;
      who_q       <= who_d;
      winner_q    <= winner_d;
      timeout_q   <= timeout_d;
      chk_start_q <= chk_start_d;
    end
  end

  // Outputs come straight from registered state and registers
  always_comb begin
    player_turn = (state_q == S_PLAYER);
    pc_turn     = (state_q == S_PC);
    timer_run   = (state_q == S_PLAYER);
    game_over   = (state_q == S_OVER);
    wr_en       = (state_q == S_COMMIT);
    chk_start   = chk_start_q;
    sec_left    = sec_q;
    wr_addr     = addr_q;
    wr_who      = who_q;
    winner      = winner_q;
    timeout     = timeout_q;
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed stimulus pushes hand-computed output snapshots
// into a queue; a monitor compares every change of the DUT outputs against
// the next queued snapshot.
module tb_turn_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       p_valid;
  logic [3:0] p_move;
  logic       pc_valid;
  logic [3:0] pc_move;
  logic       chk_done;
  logic       chk_win;
  logic       chk_draw;
  logic       player_turn;
  logic       pc_turn;
  logic       timer_run;
  logic [3:0] sec_left;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic       wr_who;
  logic       chk_start;
  logic       game_over;
  logic [1:0] winner;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] exp_q[$];
  logic [17:0] prev_obs = 18'h0;
  logic        mon_en   = 1'b0;
  logic [17:0] obs;

  turn_sequencer #(
    .TICKS_PER_SEC(4),
    .TURN_SEC     (3),
    .MOVE_W       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .p_valid    (p_valid),
    .p_move     (p_move),
    .pc_valid   (pc_valid),
    .pc_move    (pc_move),
    .chk_done   (chk_done),
    .chk_win    (chk_win),
    .chk_draw   (chk_draw),
    .player_turn(player_turn),
    .pc_turn    (pc_turn),
    .timer_run  (timer_run),
    .sec_left   (sec_left),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_who     (wr_who),
    .chk_start  (chk_start),
    .game_over  (game_over),
    .winner     (winner),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  assign obs = {player_turn, pc_turn, timer_run, sec_left, wr_en, wr_addr,
                wr_who, chk_start, game_over, winner, timeout};

  // Snapshot builder; timer_run is expected to track player_turn.
  function automatic logic [17:0] mk(input logic pt, input logic pc,
                                     input logic [3:0] sec, input logic wr,
                                     input logic [3:0] addr, input logic who,
                                     input logic cs, input logic go,
                                     input logic [1:0] win, input logic to);
    return {pt, pc, pt, sec, wr, addr, who, cs, go, win, to};
  endfunction

  task automatic push(input logic [17:0] v);
    exp_q.push_back(v);
  endtask

  // Monitor: every change in the output vector is one transaction
  always @(negedge clk) begin
    logic [17:0] e;
    if (mon_en && (obs !== prev_obs)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event got=%05h required=none", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_fail++;
          $display("FAIL event t=%0t got=%05h required=%05h", $time, obs, e);
        end else begin
          $display("event t=%0t obs=%05h ok", $time, obs);
        end
      end
      prev_obs = obs;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; p_valid = 1'b0; p_move = 4'd0;
    pc_valid = 1'b0; pc_move = 4'd0;
    chk_done = 1'b0; chk_win = 1'b0; chk_draw = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_state got=%05h required=00000", obs);
    end else begin
      $display("reset state obs=%05h ok", obs);
    end
    mon_en = 1'b1;

    // Start, countdown 3->2->1, expiry into PC with no write
    push(mk(1,0,4'd3,0,4'd0,0,0,0,2'b00,0));
    push(mk(1,0,4'd2,0,4'd0,0,0,0,2'b00,0));
    push(mk(1,0,4'd1,0,4'd0,0,0,0,2'b00,0));
    push(mk(0,1,4'd0,0,4'd0,0,0,0,2'b00,1));
    push(mk(0,1,4'd0,0,4'd0,0,0,0,2'b00,0));
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);

    // PC move 7, checker waits a few cycles, answers "continue"
    push(mk(0,0,4'd0,1,4'd7,1,0,0,2'b00,0));
    push(mk(0,0,4'd0,0,4'd7,1,1,0,2'b00,0));
    push(mk(0,0,4'd0,0,4'd7,1,0,0,2'b00,0));
    pc_valid = 1'b1; pc_move = 4'd7;
    @(negedge clk); pc_valid = 1'b0;
    repeat (3) @(negedge clk);
    push(mk(1,0,4'd3,0,4'd7,1,0,0,2'b00,0));
    chk_done = 1'b1;
    @(negedge clk); chk_done = 1'b0;

    // Player move 5; checker answers in the chk_start cycle
    push(mk(0,0,4'd3,1,4'd5,0,0,0,2'b00,0));
    push(mk(0,0,4'd3,0,4'd5,0,1,0,2'b00,0));
    push(mk(0,1,4'd3,0,4'd5,0,0,0,2'b00,0));
    p_valid = 1'b1; p_move = 4'd5;
    @(negedge clk); p_valid = 1'b0;
    @(negedge clk); chk_done = 1'b1;
    @(negedge clk); chk_done = 1'b0;
    repeat (2) @(negedge clk);

    // PC move 2 wins with draw also set: win has priority
    push(mk(0,0,4'd3,1,4'd2,1,0,0,2'b00,0));
    push(mk(0,0,4'd3,0,4'd2,1,1,0,2'b00,0));
    push(mk(0,0,4'd3,0,4'd2,1,0,0,2'b00,0));
    push(mk(0,0,4'd3,0,4'd2,1,0,1,2'b10,0));
    pc_valid = 1'b1; pc_move = 4'd2;
    @(negedge clk); pc_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); chk_done = 1'b1; chk_win = 1'b1; chk_draw = 1'b1;
    @(negedge clk); chk_done = 1'b0; chk_win = 1'b0; chk_draw = 1'b0;

    // p_valid in OVER must change nothing
    p_valid = 1'b1; p_move = 4'd4;
    @(negedge clk); p_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Restart; move lands on the exact cycle of the final wrap
    push(mk(1,0,4'd3,0,4'd2,1,0,0,2'b00,0));
    push(mk(1,0,4'd2,0,4'd2,1,0,0,2'b00,0));
    push(mk(1,0,4'd1,0,4'd2,1,0,0,2'b00,0));
    push(mk(0,0,4'd0,1,4'd9,0,0,0,2'b00,0));
    push(mk(0,0,4'd0,0,4'd9,0,1,0,2'b00,0));
    push(mk(0,0,4'd0,0,4'd9,0,0,0,2'b00,0));
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    p_valid = 1'b1; p_move = 4'd9;
    @(negedge clk); p_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while waiting in CHECK; a later chk_done is ignored
    push(mk(0,0,4'd0,0,4'd0,0,0,0,2'b00,0));
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_done = 1'b1;
    @(negedge clk); chk_done = 1'b0;
    repeat (4) @(negedge clk);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events got=%0d pending required=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
